// File: rtl/pcie_pixel_packer.sv
// Purpose : pack 32-bit filtered pixels into 64-bit words, buffer them in a FWFT FIFO for the PCIe TX/DMA engine.
// Latency : a completed word is visible at out_data one cycle after the accept edge that completes it.
// Backpr. : pix_ready drops when the FIFO holds DEPTH words; out_data/out_last hold while out_valid & !out_ready.
//
// Ports:
//   clk, n_rst                      clock, synchronous active-low reset
//   pix_data/pix_valid/pix_last     pixel stream in, pix_ready back to the filter
//   out_data/out_last/out_valid     FIFO head word out, out_ready from PCIe side
//   fifo_count                      FIFO occupancy (0..DEPTH)
//   frame_done                      one-cycle pulse after a last word is consumed

// Generic first-word-fall-through FIFO.
// Head entry is presented combinationally; rd_dat reads zero while empty.
// Writes are dropped when full, reads are ignored when empty.
module sync_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_vld && (count_q != CNT_W'(DEPTH));
  assign do_rd = rd_rdy && (count_q != '0);

  always_comb begin
    count_nxt = count_q;
    if (do_wr && !do_rd) count_nxt = count_q + CNT_W'(1);
    if (!do_wr && do_rd) count_nxt = count_q - CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt;
    end
  end

  // Storage needs no reset: stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  assign rd_vld = (count_q != '0);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
  assign count  = count_q;
endmodule

module pcie_pixel_packer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [31:0]      pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_done
);
  typedef enum logic {EMPTY_HALF, HAVE_LOW} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      half_q;
  logic             half_ld;
  logic             ready_q;
  logic             frame_done_q;
  logic             accept;
  logic             wr_vld;
  logic [64:0]      wr_dat;
  logic [64:0]      rd_dat;
  logic [CNT_W-1:0] count_nxt;

  assign accept = pix_valid && ready_q;

  always_comb begin
    state_d = state_q;
    half_ld = 1'b0;
    wr_vld  = 1'b0;
    wr_dat  = '0;
    if (accept) begin
      case (state_q)
        EMPTY_HALF: begin
          if (pix_last) begin
            // Odd frame tail: lone pixel goes out in the low half, upper half zero.
            wr_vld = 1'b1;
            wr_dat = {1'b1, 32'h0, pix_data};
          end else begin
            half_ld = 1'b1;
            state_d = HAVE_LOW;
          end
        end
        HAVE_LOW: begin
          wr_vld  = 1'b1;
          wr_dat  = {pix_last, pix_data, half_q};
          state_d = EMPTY_HALF;
        end
      endcase
    end
  end

  // ready is registered from the next occupancy so it tracks fifo_count < DEPTH
  // without a combinational path from out_ready; it is held low through reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= EMPTY_HALF;
      half_q       <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (half_ld) half_q <= pix_data;
      ready_q      <= (count_nxt < CNT_W'(DEPTH));
      frame_done_q <= out_valid && out_ready && out_last;
    end
  end

  sync_fifo #(
    .W     (65),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_vld    (wr_vld),
    .wr_dat    (wr_dat),
    .rd_rdy    (out_ready),
    .rd_vld    (out_valid),
    .rd_dat    (rd_dat),
    .count     (fifo_count),
    .count_nxt (count_nxt)
  );

  assign out_last   = rd_dat[64];
  assign out_data   = rd_dat[63:0];
  assign pix_ready  = ready_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pcie_pixel_packer.sv
module tb_pcie_pixel_packer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic [31:0]      pix_data = '0;
  logic             pix_valid = 1'b0;
  logic             pix_last = 1'b0;
  logic             pix_ready;
  logic [63:0]      out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] fifo_count;
  logic             frame_done;

  always #5 clk = ~clk;

  pcie_pixel_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  word_t       exp_q[$];
  word_t       mon_w;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_half  = '0;
  bit          m_have_low = 1'b0;
  bit          fd_pend = 1'b0;
  int          fd_seen = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference packer: predicts words as pixels are accepted.
  task automatic send_pix(input logic [31:0] d, input bit l);
    int n = 0;
    pix_data  = d;
    pix_last  = l;
    pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!pix_ready) begin
      chk("send_timeout", 1'b0, 1'b1);
    end else begin
      step(1);
      if (m_have_low) begin
        exp_q.push_back({l, d, m_half});
        m_have_low = 1'b0;
      end else if (l) begin
        exp_q.push_back({1'b1, 32'h0, d});
      end else begin
        m_half     = d;
        m_have_low = 1'b1;
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      step(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    step(2);
  endtask

  // Output scoreboard and frame_done pulse check.
  always @(negedge clk) begin
    if (!n_rst) begin
      fd_pend = 1'b0;
    end else begin
      if (fd_pend || frame_done) begin
        chk("frame_done", frame_done, fd_pend);
        if (frame_done) fd_seen++;
      end
      fd_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", {out_last, out_data}, 65'h0);
        end else begin
          mon_w = exp_q.pop_front();
          chk("out_data", out_data, mon_w.data);
          chk("out_last", out_last, mon_w.last);
        end
        fd_pend = out_last;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    n_rst = 1'b0;
    step(2);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_count", fifo_count, 0);
    chk("rst_fd", frame_done, 1'b0);
    n_rst = 1'b1;
    step(2);
    chk("idle_ready", pix_ready, 1'b1);

    // Even pairs, streaming
    out_ready = 1'b1;
    send_pix(32'h11111111, 1'b0);
    chk("lat_half_no_word", out_valid, 1'b0);
    send_pix(32'h22222222, 1'b0);
    chk("lat1_vld", out_valid, 1'b1);
    chk("lat1_dat", out_data, 64'h22222222_11111111);
    send_pix(32'h33333333, 1'b0);
    send_pix(32'h44444444, 1'b0);
    chk("lat2_vld", out_valid, 1'b1);
    chk("lat2_dat", out_data, 64'h44444444_33333333);
    chk("lat2_last", out_last, 1'b0);
    wait_drain();

    // Odd frame
    send_pix(32'hA, 1'b0);
    send_pix(32'hB, 1'b0);
    send_pix(32'hC, 1'b1);
    chk("odd_tail_dat", out_data, 64'h0000000C);
    chk("odd_tail_last", out_last, 1'b1);
    wait_drain();

    // Back-pressure: fill the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_pix(32'h100 + i, 1'b0);
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", pix_ready, 1'b0);
    chk("full_head", out_data, 64'h00000101_00000100);
    pix_data  = 32'hBAD0BAD0;
    pix_valid = 1'b1;
    step(3);
    chk("p17_count", fifo_count, DEPTH);
    chk("p17_stable", out_data, 64'h00000101_00000100);
    pix_valid = 1'b0;
    step(1);
    out_ready = 1'b1;
    begin
      int n = 0;
      while (fifo_count != 7 && n < 20) begin
        step(1);
        n++;
      end
    end
    chk("drop_count", fifo_count, 7);
    chk("drop_ready", pix_ready, 1'b1);
    wait_drain();

    // Simultaneous read/write at count 3, then a long run across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_pix(32'h200 + i, 1'b0);
    chk("rw_pre_count", fifo_count, 3);
    out_ready = 1'b1;
    send_pix(32'h207, 1'b0);
    chk("rw_count", fifo_count, 3);
    for (int i = 0; i < 40; i++) send_pix($urandom, 1'b0);
    wait_drain();

    // Reset mid-operation with count 5 and a half word held
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_pix(32'h300 + i, 1'b0);
    chk("mid_count", fifo_count, 5);
    n_rst = 1'b0;
    step(1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    chk("mid_rst_ready", pix_ready, 1'b0);
    exp_q.delete();
    m_have_low = 1'b0;
    n_rst = 1'b1;
    out_ready = 1'b1;
    send_pix(32'h12345678, 1'b0);
    send_pix(32'h9ABCDEF0, 1'b1);
    chk("post_rst_dat", out_data, 64'h9ABCDEF0_12345678);
    chk("post_rst_last", out_last, 1'b1);
    wait_drain();

    // Single-pixel frame
    send_pix(32'hDEADBEEF, 1'b1);
    chk("single_dat", out_data, 64'h00000000_DEADBEEF);
    chk("single_last", out_last, 1'b1);
    wait_drain();

    chk("fd_pulses", fd_seen, 3);
    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_pixel_packer.md
Name: pcie_pixel_packer

Overview:
- Downstream neighbour of the filter top level.
- Consumes the 32-bit filtered pixel stream, one pixel per accepted beat.
- Packs pixel pairs into 64-bit words and buffers them in a first-word-fall-through FIFO.
- Presents the words to the PCIe TX/DMA engine over a valid/ready handshake.
- Handles end-of-frame (odd pixel count) and back-pressure from PCIe.

Parameters:
- DEPTH, 8, number of 64-bit FIFO entries (power of two, >=2).
- CNT_W, 4, width of the occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- pix_data  in  32  filtered pixel from the filter top level.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_last  in  1  qualifies pix_data as the final pixel of the frame.
- pix_ready  out  1  packer can accept a pixel this cycle.
- out_data  out  64  packed word at the FIFO head.
- out_last  out  1  head word is the final word of the frame.
- out_valid  out  1  head word is valid.
- out_ready  in  1  PCIe side consumes the head word this cycle.
- fifo_count  out  CNT_W  current FIFO occupancy (0..DEPTH).
- frame_done  out  1  one-cycle pulse when a word with last=1 is consumed.

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - FIFO emptied; read/write pointers = 0; fifo_count = 0.
  - Half register and half_full flag cleared.
  - Outputs: out_valid=0, out_last=0, out_data=0 while empty, frame_done=0, pix_ready=0 during the reset cycle.
  - Reset mid-frame discards all pending pixels and words; nothing is emitted for them.
- Handshakes:
  - Pixel accepted iff pix_valid & pix_ready.
  - Word consumed iff out_valid & out_ready.
  - pix_ready = (fifo_count < DEPTH), from registered state only.
  - When full, a simultaneous read does not allow a same-cycle accept.
- Packing, one two-state FSM (EMPTY_HALF / HAVE_LOW):
  - EMPTY_HALF, accept, pix_last=0: store pixel in half register -> HAVE_LOW. No FIFO write.
  - EMPTY_HALF, accept, pix_last=1: write {32'h0, pixel}, last=1 -> stay EMPTY_HALF.
  - HAVE_LOW, accept: write {pixel, half_reg}, last=pix_last -> EMPTY_HALF.
  - Low pixel always occupies [31:0]; high pixel occupies [63:32].
  - Pixel-in to word-visible latency: 1 cycle after the accept edge that completes the word.
- FIFO:
  - Storage is 65 bits per entry (data plus last); first-word-fall-through.
  - out_data/out_last driven combinationally from the head entry.
  - out_valid = (fifo_count != 0).
  - Simultaneous write and read: fifo_count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Data at out_data must hold stable while out_valid=1 and out_ready=0.
- frame_done:
  - Registered; high the cycle after consuming a word with out_last=1.
- Illegal inputs:
  - pix_valid with pix_ready=0: ignored, no state change.
  - out_ready with out_valid=0: ignored.
- pix_last without pix_valid has no effect.

Test Plan:
- Reset, then pixels 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=1. Expect words 0x2222222211111111 then 0x4444444433333333, last=0, each 1 cycle after its second pixel.
- Odd frame: pixels 0xA, 0xB, 0xC (pix_last on 0xC). Expect 0x0000000B0000000A (last=0), then 0x000000000000000C (last=1), then a frame_done pulse one cycle after consumption.
- Back-pressure: out_ready=0, push 16 pixels. Expect fifo_count=8, pix_ready=0, the 17th pixel not accepted, out_data stable. Raise out_ready: 8 words drain in order, pix_ready returns the cycle after fifo_count drops to 7.
- Simultaneous read/write at fifo_count=3, out_ready=1, completing pair. Expect fifo_count stays 3 and pointers wrap correctly past entry 7 over 20 words.
- Reset mid-operation: n_rst=0 while fifo_count=5 and HAVE_LOW. Expect next cycle fifo_count=0, out_valid=0, frame_done=0. The first pixel after reset lands in [31:0].
- Single-pixel frame 0xDEADBEEF with pix_last. Expect word 0x00000000DEADBEEF with last=1 and a frame_done pulse.
